// File: rtl/pong_score_keeper.sv
// Pong game-state controller: owns both scores, sequences serve/play/point/game-over,
// and presents frame-synchronous score copies plus ball control strobes.
module pong_score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FRAME_TICK,
  input  logic       START,
  input  logic       BALL_OUT_LEFT,
  input  logic       BALL_OUT_RIGHT,
  output logic [7:0] PLAYER_ONE,
  output logic [7:0] PLAYER_TWO,
  output logic       BALL_RESET,
  output logic       BALL_ENABLE,
  output logic       SERVE_DIR,
  output logic       GAME_OVER,
  output logic       WINNER
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [7:0] WIN    = 8'(WIN_SCORE);
  localparam logic [7:0] FRAMES = 8'(SERVE_FRAMES);

  state_t     state, state_next;
  logic [7:0] s1, s1_next;
  logic [7:0] s2, s2_next;
  logic [7:0] frames, frames_next;
  logic       dir_next, winner_next;
  logic       start_q;
  logic       start_rise;
  logic [7:0] s1_inc, s2_inc;

  assign start_rise = START & ~start_q;
  assign s1_inc     = s1 + 8'd1;
  assign s2_inc     = s2 + 8'd1;

  always_comb begin
    state_next  = state;
    s1_next     = s1;
    s2_next     = s2;
    frames_next = frames;
    dir_next    = SERVE_DIR;
    winner_next = WINNER;
    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          s1_next     = 8'd0;
          s2_next     = 8'd0;
          frames_next = FRAMES;
          state_next  = SERVE;
        end
      end
      SERVE: begin
        if (FRAME_TICK) begin
          frames_next = frames - 8'd1;
          if (frames <= 8'd1) begin
            state_next = PLAY;
          end
        end
      end
      PLAY: begin
        // A tick coincident with a point is left to the display copy only.
        if (BALL_OUT_LEFT && BALL_OUT_RIGHT) begin
          frames_next = FRAMES;
          state_next  = SERVE;
        end else if (BALL_OUT_RIGHT) begin
          s1_next  = s1_inc;
          dir_next = 1'b1;
          if (s1_inc == WIN) begin
            winner_next = 1'b0;
            state_next  = OVER;
          end else begin
            frames_next = FRAMES;
            state_next  = SERVE;
          end
        end else if (BALL_OUT_LEFT) begin
          s2_next  = s2_inc;
          dir_next = 1'b0;
          if (s2_inc == WIN) begin
            winner_next = 1'b1;
            state_next  = OVER;
          end else begin
            frames_next = FRAMES;
            state_next  = SERVE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ball strobes and GAME_OVER are registered from the next state so they move with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s1          <= 8'd0;
      s2          <= 8'd0;
      frames      <= 8'd0;
      start_q     <= 1'b1;
      PLAYER_ONE  <= 8'd0;
      PLAYER_TWO  <= 8'd0;
      BALL_RESET  <= 1'b1;
      BALL_ENABLE <= 1'b0;
      SERVE_DIR   <= 1'b0;
      GAME_OVER   <= 1'b0;
      WINNER      <= 1'b0;
    end else begin
      state       <= state_next;
      s1          <= s1_next;
      s2          <= s2_next;
      frames      <= frames_next;
      start_q     <= START;
      BALL_RESET  <= (state_next != PLAY);
      BALL_ENABLE <= (state_next == PLAY);
      GAME_OVER   <= (state_next == OVER);
      SERVE_DIR   <= dir_next;
      WINNER      <= winner_next;
      if (FRAME_TICK) begin
        PLAYER_ONE <= s1;
        PLAYER_TWO <= s2;
      end
    end
  end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper (WIN_SCORE=3, SERVE_FRAMES=60): reset/start table, then
// hand sequences for points, frame sync, simultaneous exits, win, restart and mid-serve reset.
module tb_pong_score_keeper;

  logic       clk;
  logic       reset;
  logic       FRAME_TICK;
  logic       START;
  logic       BALL_OUT_LEFT;
  logic       BALL_OUT_RIGHT;
  logic [7:0] PLAYER_ONE;
  logic [7:0] PLAYER_TWO;
  logic       BALL_RESET;
  logic       BALL_ENABLE;
  logic       SERVE_DIR;
  logic       GAME_OVER;
  logic       WINNER;

  pong_score_keeper #(.WIN_SCORE(3), .SERVE_FRAMES(60)) dut (
    .clk            (clk),
    .reset          (reset),
    .FRAME_TICK     (FRAME_TICK),
    .START          (START),
    .BALL_OUT_LEFT  (BALL_OUT_LEFT),
    .BALL_OUT_RIGHT (BALL_OUT_RIGHT),
    .PLAYER_ONE     (PLAYER_ONE),
    .PLAYER_TWO     (PLAYER_TWO),
    .BALL_RESET     (BALL_RESET),
    .BALL_ENABLE    (BALL_ENABLE),
    .SERVE_DIR      (SERVE_DIR),
    .GAME_OVER      (GAME_OVER),
    .WINNER         (WINNER)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset          = 1'b1;
    START          = 1'b1;
    FRAME_TICK     = 1'b0;
    BALL_OUT_LEFT  = 1'b0;
    BALL_OUT_RIGHT = 1'b0;
  end

  // Output bundle: {PLAYER_ONE, PLAYER_TWO, BALL_RESET, BALL_ENABLE, SERVE_DIR, GAME_OVER, WINNER}
  localparam int W = 21;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         w_care = 1'b1;

  function automatic logic [W-1:0] o(input logic [7:0] p1, input logic [7:0] p2,
                                     input logic br, input logic be, input logic sd,
                                     input logic go, input logic w);
    return {p1, p2, br, be, sd, go, w};
  endfunction

  function automatic logic [W-1:0] serve_o(input logic [7:0] p1, input logic [7:0] p2,
                                           input logic sd);
    return o(p1, p2, 1'b1, 1'b0, sd, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] play_o(input logic [7:0] p1, input logic [7:0] p2,
                                          input logic sd);
    return o(p1, p2, 1'b0, 1'b1, sd, 1'b0, 1'b0);
  endfunction

  // scoreboard compare: pops one expectation per sampled cycle
  task automatic compare(input string name);
    logic [W-1:0] got, e, m;
    got = {PLAYER_ONE, PLAYER_TWO, BALL_RESET, BALL_ENABLE, SERVE_DIR, GAME_OVER, WINNER};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got=%h", name, got);
      return;
    end
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    checks++;
    if ((got & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: got p1=%0d p2=%0d br=%b be=%b sd=%b go=%b w=%b, exp p1=%0d p2=%0d br=%b be=%b sd=%b go=%b w=%b",
               name, got[20:13], got[12:5], got[4], got[3], got[2], got[1], got[0],
               e[20:13], e[12:5], e[4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // driver: one clock cycle of inputs, expectation for the outputs after that edge
  task automatic step(input logic rst, input logic st, input logic tick, input logic l,
                      input logic r, input logic [W-1:0] exp, input string name);
    @(negedge clk);
    reset          = rst;
    START          = st;
    FRAME_TICK     = tick;
    BALL_OUT_LEFT  = l;
    BALL_OUT_RIGHT = r;
    exp_q.push_back(exp);
    mask_q.push_back(w_care ? {W{1'b1}} : ~{{(W-1){1'b0}}, 1'b1});
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic tick_cycles(input int n, input logic [7:0] p1, input logic [7:0] p2,
                             input logic sd);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, serve_o(p1, p2, sd), "serve_tick");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, serve_o(p1, p2, sd), "serve_gap");
    end
  endtask

  task automatic run_serve(input int n, input logic [7:0] p1, input logic [7:0] p2,
                           input logic sd);
    tick_cycles(n - 1, p1, p2, sd);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, play_o(p1, p2, sd), "serve_end");
  endtask

  typedef struct {
    logic         rst;
    logic         st;
    logic         tick;
    logic         l;
    logic         r;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, serve_o(0, 0, 0), "reset_c1"};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, serve_o(0, 0, 0), "reset_c2"};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, serve_o(0, 0, 0), "reset_c3"};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, serve_o(0, 0, 0), "start_held"};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, serve_o(0, 0, 0), "idle_tick"};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, serve_o(0, 0, 0), "start_drop"};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, serve_o(0, 0, 0), "idle_ballout"};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, serve_o(0, 0, 0), "start_rise"};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, serve_o(0, 0, 0), "serve_tick1"};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, serve_o(0, 0, 0), "serve_ballout"};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].tick, tbl[i].l, tbl[i].r, tbl[i].exp, tbl[i].name);
    end

    // first serve: one tick already taken above
    run_serve(59, 0, 0, 0);

    // start edge in PLAY ignored, then a point for player one between ticks
    step(0, 0, 0, 0, 0, play_o(0, 0, 0), "play_idle");
    step(0, 1, 0, 0, 0, play_o(0, 0, 0), "play_start_ignored");
    step(0, 0, 0, 0, 0, play_o(0, 0, 0), "play_start_low");
    step(0, 0, 0, 0, 1, serve_o(0, 0, 1), "point_right");
    step(0, 0, 0, 0, 0, serve_o(0, 0, 1), "p1_held");
    step(0, 0, 1, 0, 0, serve_o(1, 0, 1), "p1_frame");
    run_serve(59, 1, 0, 1);

    // simultaneous exit: no point, direction kept
    step(0, 0, 0, 1, 1, serve_o(1, 0, 1), "both_out");
    run_serve(60, 1, 0, 1);

    // point coincident with a frame tick shows at the following tick
    step(0, 0, 1, 1, 0, serve_o(1, 0, 0), "point_on_tick");
    step(0, 0, 0, 0, 0, serve_o(1, 0, 0), "p2_held");
    run_serve(60, 1, 1, 0);

    // player two reaches WIN_SCORE=3
    step(0, 0, 0, 1, 0, serve_o(1, 1, 0), "p2_second");
    run_serve(60, 1, 2, 0);
    step(0, 0, 0, 1, 0, o(1, 2, 1, 0, 0, 1, 1), "win_point");
    step(0, 0, 0, 1, 0, o(1, 2, 1, 0, 0, 1, 1), "over_left_ignored");
    step(0, 0, 0, 0, 1, o(1, 2, 1, 0, 0, 1, 1), "over_right_ignored");
    step(0, 0, 1, 0, 0, o(1, 3, 1, 0, 0, 1, 1), "win_display");
    step(0, 0, 1, 1, 1, o(1, 3, 1, 0, 0, 1, 1), "over_hold");

    // restart from OVER; WINNER is meaningless once GAME_OVER drops
    w_care = 1'b0;
    step(0, 1, 0, 0, 0, o(1, 3, 1, 0, 0, 0, 0), "restart");
    step(0, 0, 1, 0, 0, serve_o(0, 0, 0), "restart_display");
    run_serve(59, 0, 0, 0);

    // build score 2-1, then reset with the frame counter at 20
    step(0, 0, 0, 0, 1, serve_o(0, 0, 1), "s1_to_1");
    run_serve(60, 1, 0, 1);
    step(0, 0, 0, 0, 1, serve_o(1, 0, 1), "s1_to_2");
    run_serve(60, 2, 0, 1);
    step(0, 0, 0, 1, 0, serve_o(2, 0, 0), "s2_to_1");
    tick_cycles(40, 2, 1, 0);
    w_care = 1'b1;
    step(1, 1, 1, 1, 1, o(0, 0, 1, 0, 0, 0, 0), "reset_mid_serve");
    step(0, 1, 0, 0, 0, o(0, 0, 1, 0, 0, 0, 0), "post_reset_idle");
    step(0, 1, 1, 0, 0, o(0, 0, 1, 0, 0, 0, 0), "post_reset_tick");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
